data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Sits between the pipeline's MEM stage and the single-ported data memory and shares that memory with a host loader port. The host port moves RSA operands and keys in and results out as auto-incrementing word bursts. The CPU owns the memory by default. A host burst steals cycles under a bounded-starvation policy, and the CPU is stalled only on the cycles it loses.

## Interface
Parameters:
- BURST_W, 8, width of burst length and beat counter (max burst 2^BURST_W−1 words)
- STARVE_LIMIT, 4, max consecutive CPU-won cycles while a host beat is pending; range 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  MEM stage performs a load or store this cycle
- cpu_we  in  1  store when 1, load when 0
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, = mem_rdata
- cpu_stall  out  1  CPU lost arbitration this cycle; pipeline must hold MEM stage
- host_start  in  1  start burst; sampled only in ARB_IDLE
- host_we  in  1  burst direction, latched at start
- host_base  in  32  burst byte base, latched at start; bits [1:0] ignored
- host_len  in  BURST_W  words in burst, latched at start
- host_wdata  in  32  write beat data
- host_wvalid  in  1  write beat data available
- host_wready  out  1  write beat accepted this cycle
- host_rdata  out  32  read beat data, = mem_rdata
- host_rvalid  out  1  read beat valid this cycle
- host_busy  out  1  burst in progress (ARB_BURST)
- host_done  out  1  one-cycle pulse after the last beat
- mem_we, mem_addr[32], mem_wdata[32]  out  to data memory
- mem_rdata  in  32  combinational read data from memory

## Operation
- **Memory model.** The memory reads combinationally and writes at the clock edge. A granted access completes in the cycle it is granted.
- **FSM states:** ARB_IDLE, ARB_BURST, ARB_DONE.
- **ARB_IDLE.**
  - The CPU owns the memory: mem_* = cpu_* and mem_we = cpu_req & cpu_we.
  - cpu_stall = 0.
  - On host_start: latch we, base (with [1:0] forced to 00), and len; clear idx and starve_cnt.
  - If len = 0, go to ARB_DONE. Otherwise go to ARB_BURST.
- **ARB_BURST.** A host beat is pending when host_we = 0, or when host_we = 1 and host_wvalid = 1. Each cycle:
  - **CPU wins** if cpu_req = 1 and (no beat is pending, or starve_cnt < STARVE_LIMIT).
    - starve_cnt increments only when a beat was pending.
  - **Host wins** otherwise, provided a beat is pending.
    - mem_addr = base + 4·idx, mod 2^32.
    - Write beat: mem_we = 1, mem_wdata = host_wdata, host_wready = 1.
    - Read beat: mem_we = 0, host_rvalid = 1.
    - cpu_stall = cpu_req.
    - starve_cnt resets to 0 and idx increments.
  - **Idle cycle.** If neither side wins: mem_we = 0 and nothing advances.
  - **Last beat.** A host beat with idx = len−1 moves the FSM to ARB_DONE.
- **ARB_DONE.**
  - host_done = 1 for exactly one cycle.
  - The CPU owns the memory as in ARB_IDLE.
  - Next state is ARB_IDLE.
  - host_start is ignored in this state.
- **host_start outside ARB_IDLE** is ignored. The latched parameters are never disturbed.
- **Reset** (rst_n = 0 at an edge): state ARB_IDLE, idx = 0, starve_cnt = 0.
  - An in-flight burst is aborted with no host_done.
  - While rst_n = 0, mem_we, cpu_stall, host_wready and host_rvalid are forced to 0.
- **Outputs after reset:** cpu_stall = 0, host_busy = 0, host_done = 0, host_wready = 0, host_rvalid = 0. mem_we follows cpu_req & cpu_we.

## Timing
- Grant, the mem_* mux, cpu_stall, host_wready and host_rvalid are combinational from the registered state and the current inputs. There are zero cycles of added latency on either port.
- host_busy is registered and is 1 from the cycle after an accepted host_start through the last beat.
- host_done is asserted the cycle after the last beat.
- An uncontended burst of N words completes in N cycles, with host_done on cycle N+1.
- Under continuous cpu_req with beats always pending, the host gets 1 cycle out of every STARVE_LIMIT+1.
- A new host_start is accepted at the earliest in the cycle after ARB_DONE.

## Structure
- **Package data_mem_arb_pkg:**
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_BURST, ARB_DONE}
  - localparam WORD_BYTES = 4
- **Sub-module burst_addr_gen:** holds the latched base, the idx counter, the last-beat compare and the address output. The arbiter instantiates it once.

## Test plan
- **Idle passthrough:** cpu_req=1, cpu_we=1, cpu_addr=0x10, cpu_wdata=0xDEADBEEF → mem_we=1, mem_addr=0x10, cpu_stall=0; a following load at 0x10 returns 0xDEADBEEF.
- **Uncontended write burst:** base=0x100, len=3, host_wvalid held 1, cpu_req=0 → writes to 0x100, 0x104 and 0x108 on three consecutive cycles; host_done pulse on the 4th cycle; host_busy drops the same cycle.
- **Contended read burst:** len=2, STARVE_LIMIT=4, cpu_req held 1 → the CPU wins 4 cycles, the host wins cycle 5 (cpu_stall=1, host_rvalid=1), the CPU wins 4 more, the host wins again, then host_done.
- **Write gaps:** len=2 with host_wvalid low for 3 cycles mid-burst and cpu_req=1 → the CPU is granted and never stalled during the gap; starve_cnt is unchanged; both words land at base and base+4.
- **Zero length and stray start:** host_len=0 → host_done the next cycle, no host write. host_start pulsed during a 4-word burst → ignored; the original base and len complete.
- **Reset mid-burst:** rst_n low after beat 1 of 4 → no host_done, host_busy=0; a new burst at 0x200 starts at idx 0.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM encoding and word size.
package data_mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BURST,
      ARB_DONE
   } arb_state_t;

   localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/burst_addr_gen.sv
// Host burst address generator: holds the word-aligned base, length and beat
// index, and flags the final beat of the burst.
module burst_addr_gen
   import data_mem_arb_pkg::*;
#(
   parameter int unsigned BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [31:0]        base_i,
   input  logic [BURST_W-1:0] len_i,
   input  logic               advance_i,
   output logic [31:0]        addr_o,
   output logic               last_o
);

   localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

   logic [31:0]        base_q, base_d;
   logic [BURST_W-1:0] len_q, len_d;
   logic [BURST_W-1:0] idx_q, idx_d;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      base_d = base_q;
      len_d  = len_q;
      idx_d  = idx_q;
      if (load_i) begin
         base_d = base_i & ~32'h3;
         len_d  = len_i;
         idx_d  = '0;
      end else if (advance_i) begin
         idx_d = idx_q + ONE;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_q <= '0;
         len_q  <= '0;
         idx_q  <= '0;
      end else begin
         base_q <= base_d;
         len_q  <= len_d;
         idx_q  <= idx_d;
      end
   end

   // Address wraps modulo 2^32 naturally through the 32-bit add.
   assign addr_o = base_q + 32'(WORD_BYTES) * 32'(idx_q);
   assign last_o = (idx_q == len_q - ONE);

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-ported data memory between the MEM stage and a host burst
// port; the host steals a cycle after at most STARVE_LIMIT CPU wins.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int unsigned BURST_W      = 8,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [31:0]        cpu_addr,
   input  logic [31:0]        cpu_wdata,
   output logic [31:0]        cpu_rdata,
   output logic               cpu_stall,
   input  logic               host_start,
   input  logic               host_we,
   input  logic [31:0]        host_base,
   input  logic [BURST_W-1:0] host_len,
   input  logic [31:0]        host_wdata,
   input  logic               host_wvalid,
   output logic               host_wready,
   output logic [31:0]        host_rdata,
   output logic               host_rvalid,
   output logic               host_busy,
   output logic               host_done,
   output logic               mem_we,
   output logic [31:0]        mem_addr,
   output logic [31:0]        mem_wdata,
   input  logic [31:0]        mem_rdata
);

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   arb_state_t  state_q, state_d;
   logic        hwe_q, hwe_d;
   logic [3:0]  starve_q, starve_d;
   logic        accept, beat_pending, cpu_win, host_win, last_beat;
   logic [31:0] burst_addr;

   assign accept = (state_q == ARB_IDLE) && host_start;

   burst_addr_gen #(.BURST_W(BURST_W)) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (accept),
      .base_i    (host_base),
      .len_i     (host_len),
      .advance_i (host_win),
      .addr_o    (burst_addr),
      .last_o    (last_beat)
   );

   always_comb begin
      state_d      = state_q;
      hwe_d        = hwe_q;
      starve_d     = starve_q;
      mem_we       = cpu_req & cpu_we;
      mem_addr     = cpu_addr;
      mem_wdata    = cpu_wdata;
      cpu_stall    = 1'b0;
      host_wready  = 1'b0;
      host_rvalid  = 1'b0;
      beat_pending = 1'b0;
      cpu_win      = 1'b0;
      host_win     = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (host_start) begin
               hwe_d    = host_we;
               starve_d = '0;
               state_d  = (host_len == '0) ? ARB_DONE : ARB_BURST;
            end
         end
         ARB_BURST: begin
            beat_pending = !hwe_q || host_wvalid;
            cpu_win      = cpu_req && (!beat_pending || starve_q < STARVE_MAX);
            host_win     = !cpu_win && beat_pending;
            if (cpu_win) begin
               // Starvation only accrues while the host actually has a beat waiting.
               if (beat_pending) starve_d = starve_q + 4'd1;
            end else if (host_win) begin
               mem_addr    = burst_addr;
               mem_we      = hwe_q;
               mem_wdata   = host_wdata;
               host_wready = hwe_q;
               host_rvalid = !hwe_q;
               cpu_stall   = cpu_req;
               starve_d    = '0;
               if (last_beat) state_d = ARB_DONE;
            end else begin
               mem_we = 1'b0;
            end
         end
         ARB_DONE: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
      if (!rst_n) begin
         mem_we      = 1'b0;
         cpu_stall   = 1'b0;
         host_wready = 1'b0;
         host_rvalid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ARB_IDLE;
         hwe_q    <= 1'b0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         hwe_q    <= hwe_d;
         starve_q <= starve_d;
      end
   end

   assign cpu_rdata  = mem_rdata;
   assign host_rdata = mem_rdata;
   assign host_busy  = (state_q == ARB_BURST);
   assign host_done  = (state_q == ARB_DONE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, scored against
// a queue-of-beats reference model and a shadow copy of memory.
module tb_data_mem_arbiter;

   localparam int BW    = 8;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_req, cpu_we, cpu_stall;
   logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
   logic          host_start, host_we, host_wvalid, host_wready;
   logic [31:0]   host_base, host_wdata, host_rdata;
   logic [BW-1:0] host_len;
   logic          host_rvalid, host_busy, host_done;
   logic          mem_we;
   logic [31:0]   mem_addr, mem_wdata, mem_rdata;

   data_mem_arbiter #(.BURST_W(BW), .STARVE_LIMIT(LIMIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_stall   (cpu_stall),
      .host_start  (host_start),
      .host_we     (host_we),
      .host_base   (host_base),
      .host_len    (host_len),
      .host_wdata  (host_wdata),
      .host_wvalid (host_wvalid),
      .host_wready (host_wready),
      .host_rdata  (host_rdata),
      .host_rvalid (host_rvalid),
      .host_busy   (host_busy),
      .host_done   (host_done),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory: combinational read, write at the edge; 256 words aliased by addr[9:2].
   logic [31:0] ram [256] = '{default: 32'h0};
   assign mem_rdata = ram[mem_addr[9:2]];
   always @(posedge clk) if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
   } beat_t;

   beat_t       beat_q[$];
   logic [31:0] ref_mem [256] = '{default: 32'h0};
   int          starve   = 0;
   bit          done_due = 1'b0;
   int          total    = 0;
   int          bad      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model and monitor: every cycle, decide from the rules what should
   // happen and compare; a burst is active while expected beats remain queued.
   always @(negedge clk) begin : monitor
      bit    active, pending, host_exp, done_next;
      beat_t b;
      done_next = 1'b0;
      if (!rst_n) begin
         check("rst_mem_we", mem_we, 0);
         check("rst_stall", cpu_stall, 0);
         check("rst_wready", host_wready, 0);
         check("rst_rvalid", host_rvalid, 0);
         beat_q.delete();
         starve = 0;
      end else begin
         active = beat_q.size() != 0;
         check("host_done", host_done, done_due);
         check("host_busy", host_busy, active);
         pending  = active && (!beat_q[0].we || host_wvalid);
         host_exp = pending && !(cpu_req && starve < LIMIT);
         check("host_grant", host_wready | host_rvalid, host_exp);
         if (host_exp) begin
            b = beat_q.pop_front();
            check("beat_addr", mem_addr, b.addr);
            check("beat_stall", cpu_stall, cpu_req);
            check("beat_mem_we", mem_we, b.we);
            if (b.we) begin
               check("beat_rvalid_low", host_rvalid, 0);
               check("beat_wdata", mem_wdata, host_wdata);
               ref_mem[b.addr[9:2]] = host_wdata;
            end else begin
               check("beat_wready_low", host_wready, 0);
               check("beat_rdata", host_rdata, ref_mem[b.addr[9:2]]);
            end
            starve = 0;
            if (beat_q.size() == 0) done_next = 1'b1;
         end else begin
            check("cpu_stall", cpu_stall, 0);
            if (cpu_req) begin
               check("cpu_mem_addr", mem_addr, cpu_addr);
               check("cpu_mem_we", mem_we, cpu_we);
               if (cpu_we) begin
                  check("cpu_mem_wdata", mem_wdata, cpu_wdata);
                  ref_mem[cpu_addr[9:2]] = cpu_wdata;
               end else begin
                  check("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[9:2]]);
               end
               if (pending) starve++;
            end else begin
               check("idle_mem_we", mem_we, 0);
            end
         end
         if (!active && !done_due && host_start) begin
            if (host_len == '0) done_next = 1'b1;
            else for (int i = 0; i < int'(host_len); i++)
               beat_q.push_back('{addr: (host_base & ~32'h3) + 32'(4 * i), we: host_we});
         end
      end
      done_due = done_next;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      host_start = 0; host_we = 0; host_base = '0; host_len = '0;
      host_wdata = '0; host_wvalid = 0;
   endtask

   task automatic start_burst(input logic we, input logic [31:0] base, input logic [BW-1:0] len);
      host_start = 1; host_we = we; host_base = base; host_len = len;
      tick();
      host_start = 0;
   endtask

   initial begin
      clear_in();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // Idle passthrough: store then load at 0x10.
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
      @(negedge clk);
      check("pt_mem_we", mem_we, 1);
      check("pt_mem_addr", mem_addr, 32'h10);
      check("pt_stall", cpu_stall, 0);
      tick();
      cpu_we = 0;
      @(negedge clk);
      check("pt_load", cpu_rdata, 32'hDEADBEEF);
      tick();
      cpu_req = 0;

      // Uncontended write burst of 3 at 0x100.
      host_wvalid = 1;
      start_burst(1, 32'h100, 3);
      for (int k = 0; k < 3; k++) begin
         host_wdata = $urandom;
         @(negedge clk);
         check("wb_addr", mem_addr, 32'h100 + 32'(4 * k));
         tick();
      end
      host_wvalid = 0;
      @(negedge clk);
      check("wb_done", host_done, 1);
      check("wb_busy", host_busy, 0);
      tick();

      // Contended read burst of 2 with cpu_req held.
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
      start_burst(0, 32'h100, 2);
      for (int k = 1; k <= 10; k++) begin
         cpu_addr = 32'($urandom_range(0, 255)) << 2;
         @(negedge clk);
         check("cr_rvalid", host_rvalid, (k % 5 == 0) ? 1 : 0);
         check("cr_stall", cpu_stall, (k % 5 == 0) ? 1 : 0);
         tick();
      end
      @(negedge clk);
      check("cr_done", host_done, 1);
      tick();

      // Write burst with a 3-cycle data gap under CPU pressure.
      start_burst(1, 32'h180, 2);
      host_wvalid = 1; host_wdata = 32'hA5A5_0001;
      repeat (5) tick();
      host_wvalid = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("gap_stall", cpu_stall, 0);
         check("gap_cpu_addr", mem_addr, cpu_addr);
         tick();
      end
      host_wvalid = 1; host_wdata = 32'hA5A5_0002;
      repeat (5) tick();
      host_wvalid = 0; cpu_addr = 32'h180;
      @(negedge clk);
      check("gap_word0", cpu_rdata, 32'hA5A5_0001);
      tick();
      cpu_addr = 32'h184;
      @(negedge clk);
      check("gap_word1", cpu_rdata, 32'hA5A5_0002);
      tick();
      cpu_req = 0;

      // Zero-length burst.
      host_wvalid = 1; host_wdata = 32'h0BAD_0BAD;
      start_burst(1, 32'h1C0, 0);
      @(negedge clk);
      check("zl_done", host_done, 1);
      check("zl_wready", host_wready, 0);
      tick();

      // Stray starts during a burst and during the done cycle.
      start_burst(1, 32'h40, 4);
      host_start = 1; host_base = 32'h300; host_len = 9;
      tick();
      host_start = 0;
      repeat (3) tick();
      host_start = 1; host_base = 32'h300; host_len = 2;
      @(negedge clk);
      check("ss_done", host_done, 1);
      tick();
      host_start = 0;

      // Address wrap past 2^32 with an unaligned base.
      start_burst(1, 32'hFFFF_FFFA, 3);
      repeat (4) tick();

      // Reset after the first beat of a 4-beat burst.
      start_burst(1, 32'h40, 4);
      tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      @(negedge clk);
      check("rb_busy", host_busy, 0);
      check("rb_done", host_done, 0);
      tick();
      start_burst(1, 32'h200, 2);
      @(negedge clk);
      check("rb_new_addr", mem_addr, 32'h200);
      tick();
      repeat (2) tick();
      host_wvalid = 0;

      // Random traffic.
      for (int n = 0; n < 4000; n++) begin
         cpu_req     = ($urandom_range(0, 3) != 0);
         cpu_we      = 1'($urandom);
         cpu_addr    = 32'($urandom_range(0, 255)) << 2;
         cpu_wdata   = $urandom;
         host_wvalid = ($urandom_range(0, 3) != 0);
         host_wdata  = $urandom;
         host_start  = ($urandom_range(0, 7) == 0);
         host_we     = 1'($urandom);
         host_base   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
         host_len    = BW'($urandom_range(0, 6));
         rst_n       = ($urandom_range(0, 499) != 0);
         tick();
      end
      rst_n = 1;
      clear_in();
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
